// File: rtl/if_id_pkg.sv
// Shared types and MIPS-32 field positions for the IF->ID pipeline buffer.
package if_id_pkg;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_J = 2'd2
  } fmt_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;

  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM_LSB   = 0;
  localparam int unsigned ADDR_LSB  = 0;

endpackage

// File: rtl/if_id_field_decode.sv
// Combinational R/I/J field split of one instruction; unused fields are forced to zero.
module if_id_field_decode
  import if_id_pkg::*;
#(
  parameter int unsigned INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output fmt_e               fmt,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         funct,
  output logic [15:0]        imm16,
  output logic [25:0]        addr26
);

  always_comb begin
    opcode = instr[OPC_LSB +: 6];
    fmt    = FMT_I;
    rs     = '0;
    rt     = '0;
    rd     = '0;
    shamt  = '0;
    funct  = '0;
    imm16  = '0;
    addr26 = '0;
    if (opcode == OPC_RTYPE) begin
      fmt   = FMT_R;
      rs    = instr[RS_LSB +: 5];
      rt    = instr[RT_LSB +: 5];
      rd    = instr[RD_LSB +: 5];
      shamt = instr[SHAMT_LSB +: 5];
      funct = instr[FUNCT_LSB +: 6];
    end else if (opcode == OPC_J || opcode == OPC_JAL) begin
      fmt    = FMT_J;
      addr26 = instr[ADDR_LSB +: 26];
    end else begin
      rs    = instr[RS_LSB +: 5];
      rt    = instr[RT_LSB +: 5];
      imm16 = instr[IMM_LSB +: 16];
    end
  end

endmodule

// File: rtl/if_id_pipe_buffer.sv
// IF->ID stage as a DEPTH-entry ready/valid queue with flush and head decode.
// Optional stall/flush performance counters when IF_ID_PERF_CNT_EN is defined.
module if_id_pipe_buffer
  import if_id_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 9,
  parameter int unsigned DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output fmt_e               fmt,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         funct,
  output logic [15:0]        imm16,
  output logic [25:0]        addr26
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [INSTR_W-1:0] mem_instr [DEPTH];
  logic [PC_W-1:0]    mem_pc    [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               push;
  logic               pop;

  assign in_ready  = (count != CNT_FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= in_instr;
        mem_pc[wr_ptr]    <= in_pc;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head is zero-gated when empty so the decoded fields never show stale data.
  assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
  assign out_pc    = out_valid ? mem_pc[rd_ptr]    : '0;

  if_id_field_decode #(
    .INSTR_W(INSTR_W)
  ) u_decode (
    .instr (out_instr),
    .fmt   (fmt),
    .opcode(opcode),
    .rs    (rs),
    .rt    (rt),
    .rd    (rd),
    .shamt (shamt),
    .funct (funct),
    .imm16 (imm16),
    .addr26(addr26)
  );

`ifdef IF_ID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush && count != '0 && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_pipe_buffer.sv
// Scoreboard bench: DEPTH=2 instance for directed cases, DEPTH=4 instance for wrap/reset stream.
module tb_if_id_pipe_buffer;

  typedef struct packed {
    logic [31:0] instr;
    logic [8:0]  pc;
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] addr;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  // DEPTH=2 instance signals
  logic        in_valid_a = 0, in_ready_a, flush_a = 0, out_valid_a, out_ready_a = 0;
  logic [31:0] in_instr_a = '0, out_instr_a;
  logic [8:0]  in_pc_a = '0, out_pc_a;
  logic [1:0]  fmt_a;
  logic [5:0]  opcode_a, funct_a;
  logic [4:0]  rs_a, rt_a, rd_a, shamt_a;
  logic [15:0] imm16_a;
  logic [25:0] addr26_a;
  // DEPTH=4 instance signals
  logic        in_valid_b = 0, in_ready_b, flush_b = 0, out_valid_b, out_ready_b = 0;
  logic [31:0] in_instr_b = '0, out_instr_b;
  logic [8:0]  in_pc_b = '0, out_pc_b;
  logic [1:0]  fmt_b;
  logic [5:0]  opcode_b, funct_b;
  logic [4:0]  rs_b, rt_b, rd_b, shamt_b;
  logic [15:0] imm16_b;
  logic [25:0] addr26_b;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;
`endif

  if_id_pipe_buffer #(.INSTR_W(32), .PC_W(9), .DEPTH(2)) u_dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_instr(in_instr_a), .in_pc(in_pc_a), .flush(flush_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_instr(out_instr_a), .out_pc(out_pc_a), .fmt(fmt_a),
    .opcode(opcode_a), .rs(rs_a), .rt(rt_a), .rd(rd_a), .shamt(shamt_a), .funct(funct_a),
    .imm16(imm16_a), .addr26(addr26_a)
`ifdef IF_ID_PERF_CNT_EN
    , .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
`endif
  );

  if_id_pipe_buffer #(.INSTR_W(32), .PC_W(9), .DEPTH(4)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_instr(in_instr_b), .in_pc(in_pc_b), .flush(flush_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_instr(out_instr_b), .out_pc(out_pc_b), .fmt(fmt_b),
    .opcode(opcode_b), .rs(rs_b), .rt(rt_b), .rd(rd_b), .shamt(shamt_b), .funct(funct_b),
    .imm16(imm16_b), .addr26(addr26_b)
`ifdef IF_ID_PERF_CNT_EN
    , .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
`endif
  );

  obs_t obs_a, obs_b;
  assign obs_a = {out_instr_a, out_pc_a, fmt_a, opcode_a, rs_a, rt_a, rd_a, shamt_a, funct_a, imm16_a, addr26_a};
  assign obs_b = {out_instr_b, out_pc_b, fmt_b, opcode_b, rs_b, rt_b, rd_b, shamt_b, funct_b, imm16_b, addr26_b};

  obs_t qa[$];
  obs_t qb[$];
  int   pops_b = 0;

  function automatic obs_t model(input logic [31:0] i, input logic [8:0] p);
    obs_t o = '0;
    o.instr = i;
    o.pc    = p;
    o.op    = i[31:26];
    if (o.op == 6'h00) begin
      o.rs = i[25:21]; o.rt = i[20:16]; o.rd = i[15:11]; o.sh = i[10:6]; o.fn = i[5:0];
    end else if (o.op == 6'h02 || o.op == 6'h03) begin
      o.fmt = 2'd2; o.addr = i[25:0];
    end else begin
      o.fmt = 2'd1; o.rs = i[25:21]; o.rt = i[20:16]; o.imm = i[15:0];
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_obs(input string tag, input obs_t act, input obs_t exp);
    chk({tag, ".instr"}, act.instr, exp.instr);
    chk({tag, ".pc"},    32'(act.pc),   32'(exp.pc));
    chk({tag, ".fmt"},   32'(act.fmt),  32'(exp.fmt));
    chk({tag, ".op"},    32'(act.op),   32'(exp.op));
    chk({tag, ".rs"},    32'(act.rs),   32'(exp.rs));
    chk({tag, ".rt"},    32'(act.rt),   32'(exp.rt));
    chk({tag, ".rd"},    32'(act.rd),   32'(exp.rd));
    chk({tag, ".shamt"}, 32'(act.sh),   32'(exp.sh));
    chk({tag, ".funct"}, 32'(act.fn),   32'(exp.fn));
    chk({tag, ".imm16"}, 32'(act.imm),  32'(exp.imm));
    chk({tag, ".addr26"}, 32'(act.addr), 32'(exp.addr));
  endtask

  // Monitor for the DEPTH=2 instance: compare head, then advance the model by this cycle's handshakes.
  int unsigned st_a = 0, fl_a = 0;
  always @(negedge clk) begin : mon_a
    logic rdy;
    if (mon_en) begin
      rdy = (qa.size() != 2);
      chk("a.in_ready", 32'(in_ready_a), 32'(rdy));
      chk("a.out_valid", 32'(out_valid_a), 32'(qa.size() != 0));
      check_obs("a.head", obs_a, (qa.size() != 0) ? qa[0] : obs_t'('0));
`ifdef IF_ID_PERF_CNT_EN
      chk("a.stall_cnt", stall_cnt_a, st_a);
      chk("a.flush_cnt", flush_cnt_a, fl_a);
`endif
      if (reset) begin
        qa.delete(); st_a = 0; fl_a = 0;
      end else begin
        if (in_valid_a && !rdy) st_a++;
        if (flush_a && qa.size() != 0) fl_a++;
        if (flush_a) qa.delete();
        else begin
          if (out_ready_a && qa.size() != 0) void'(qa.pop_front());
          if (in_valid_a && rdy) qa.push_back(model(in_instr_a, in_pc_a));
        end
      end
    end
  end

  int unsigned st_b = 0, fl_b = 0;
  always @(negedge clk) begin : mon_b
    logic rdy;
    if (mon_en) begin
      rdy = (qb.size() != 4);
      chk("b.in_ready", 32'(in_ready_b), 32'(rdy));
      chk("b.out_valid", 32'(out_valid_b), 32'(qb.size() != 0));
      check_obs("b.head", obs_b, (qb.size() != 0) ? qb[0] : obs_t'('0));
`ifdef IF_ID_PERF_CNT_EN
      chk("b.stall_cnt", stall_cnt_b, st_b);
      chk("b.flush_cnt", flush_cnt_b, fl_b);
`endif
      if (reset) begin
        qb.delete(); st_b = 0; fl_b = 0;
      end else begin
        if (in_valid_b && !rdy) st_b++;
        if (flush_b && qb.size() != 0) fl_b++;
        if (flush_b) qb.delete();
        else begin
          if (out_ready_b && qb.size() != 0) begin void'(qb.pop_front()); pops_b++; end
          if (in_valid_b && rdy) qb.push_back(model(in_instr_b, in_pc_b));
        end
      end
    end
  end

  task automatic step_a(input logic iv, input logic [31:0] ins, input logic [8:0] pc,
                        input logic ordy, input logic fl);
    in_valid_a = iv; in_instr_a = ins; in_pc_a = pc; out_ready_a = ordy; flush_a = fl;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic iv, input logic [31:0] ins, input logic [8:0] pc, input logic ordy);
    in_valid_b = iv; in_instr_b = ins; in_pc_b = pc; out_ready_b = ordy;
    @(posedge clk); #1;
  endtask

  logic [31:0] stream_tbl [4] = '{32'h8C220004, 32'h0C000040, 32'h00851020, 32'h08000123};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int pushed;
    int guard;
    reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    step_a(0, '0, '0, 0, 0);
    reset = 1'b0;
    chk("reset.in_ready", 32'(in_ready_a), 32'd1);

    // 1: I-type load
    step_a(1, 32'h8C220004, 9'h010, 0, 0);
    chk("t1.out_valid", 32'(out_valid_a), 32'd1);
    chk("t1.fmt", 32'(fmt_a), 32'd1);
    chk("t1.rs", 32'(rs_a), 32'd1);
    chk("t1.rt", 32'(rt_a), 32'd2);
    chk("t1.imm16", 32'(imm16_a), 32'h0004);
    chk("t1.rd", 32'(rd_a), 32'd0);
    step_a(0, '0, '0, 1, 0);

    // 2: fill, third offer ignored, drain in order
    step_a(1, 32'h24010001, 9'h020, 0, 0);
    step_a(1, 32'h24020002, 9'h024, 0, 0);
    chk("t2.in_ready_full", 32'(in_ready_a), 32'd0);
    step_a(1, 32'h24030003, 9'h028, 0, 0);
    step_a(0, '0, '0, 1, 0);
    chk("t2.pop1_pc", 32'(out_pc_a), 32'h024);
    step_a(0, '0, '0, 1, 0);

    // 3: full with offer held, then pop while full (offer not taken), then accepted
    step_a(1, 32'h24040004, 9'h030, 0, 0);
    step_a(1, 32'h24050005, 9'h034, 0, 0);
    step_a(1, 32'h24060006, 9'h038, 0, 0);
    step_a(1, 32'h24060006, 9'h038, 0, 0);
    chk("t3.hold_pc", 32'(out_pc_a), 32'h030);
    step_a(1, 32'h24060006, 9'h038, 1, 0);
    chk("t3.after_pop_pc", 32'(out_pc_a), 32'h034);
    step_a(1, 32'h24060006, 9'h038, 0, 0);
    step_a(0, '0, '0, 1, 0);
    step_a(0, '0, '0, 1, 0);

    // 4: J then R decode
    step_a(1, 32'h0C000040, 9'h040, 0, 0);
    chk("t4.j_fmt", 32'(fmt_a), 32'd2);
    chk("t4.j_addr26", 32'(addr26_a), 32'h0000040);
    chk("t4.j_rs", 32'(rs_a), 32'd0);
    chk("t4.j_imm16", 32'(imm16_a), 32'd0);
    step_a(1, 32'h00851020, 9'h044, 1, 0);
    chk("t4.r_fmt", 32'(fmt_a), 32'd0);
    chk("t4.r_rd", 32'(rd_a), 32'd2);
    chk("t4.r_funct", 32'(funct_a), 32'h20);
    chk("t4.r_rs", 32'(rs_a), 32'd4);
    chk("t4.r_rt", 32'(rt_a), 32'd5);
    step_a(0, '0, '0, 1, 0);

    // 5: flush while full with push and pop offered
    step_a(1, 32'h24070007, 9'h050, 0, 0);
    step_a(1, 32'h24080008, 9'h054, 0, 0);
    step_a(1, 32'h24090009, 9'h058, 1, 1);
    chk("t5.out_valid", 32'(out_valid_a), 32'd0);
    chk("t5.in_ready", 32'(in_ready_a), 32'd1);
`ifdef IF_ID_PERF_CNT_EN
    chk("t5.flush_cnt", flush_cnt_a, 32'd1);
`endif
    step_a(0, '0, '0, 0, 0);

    // 6: DEPTH=4 stream across pointer wrap
    pushed = 0;
    guard = 0;
    while (pushed < 10 && guard < 300) begin
      logic acc;
      acc = in_ready_b;
      step_b(1, stream_tbl[pushed % 4], 9'(9'h100 + pushed * 4), 1'($urandom_range(0, 1)));
      if (acc) pushed++;
      guard++;
    end
    guard = 0;
    while (out_valid_b && guard < 20) begin
      step_b(0, '0, '0, 1);
      guard++;
    end
    step_b(0, '0, '0, 0);
    chk("t6.pops", pops_b, 32'd10);

    // reset mid-stream drops held entries
    step_b(1, 32'h24010001, 9'h1A0, 0);
    step_b(1, 32'h24020002, 9'h1A4, 0);
    step_b(1, 32'h24030003, 9'h1A8, 0);
    reset = 1'b1;
    step_b(1, 32'h24040004, 9'h1AC, 0);
    reset = 1'b0;
    chk("t6.rst_out_valid", 32'(out_valid_b), 32'd0);
    chk("t6.rst_in_ready", 32'(in_ready_b), 32'd1);
    step_b(0, '0, '0, 0);
    step_b(0, '0, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
